// File: rtl/plab4_net_router_output_ctrl.sv
// Output-port controller for one router output: round-robin arbitration
// between packets, with the output locked to one input from head to tail flit.
module plab4_net_router_output_ctrl #(
  parameter int p_num_reqs = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [p_num_reqs-1:0] reqs,
  input  logic [p_num_reqs-1:0] req_tail,
  output logic [p_num_reqs-1:0] grants,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [1:0]            sel
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(p_num_reqs - 1);

  state_t                  state;
  state_t                  state_next;
  logic [p_num_reqs-1:0]   prio;
  logic [p_num_reqs-1:0]   prio_next;
  logic [1:0]              lock_id;
  logic [1:0]              lock_id_next;

  logic [1:0]              prio_idx;
  logic [1:0]              cand;
  logic                    win_vld;
  logic [1:0]              win_idx;
  logic                    xfer;

  // Next index around the ring of requesters (wraps N-1 -> 0).
  function automatic logic [1:0] idx_inc(input logic [1:0] i);
    if (i == LAST_IDX) return 2'd0;
    else               return i + 2'd1;
  endfunction

  function automatic logic [p_num_reqs-1:0] to_onehot(input logic [1:0] i);
    logic [p_num_reqs-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Convert the one-hot priority pointer to the index where the search starts.
  always_comb begin
    prio_idx = 2'd0;
    for (int i = 0; i < p_num_reqs; i++) begin
      if (prio[i]) prio_idx = 2'(i);
    end
  end

  // Winner selection; while LOCKED only the locking input is looked at, so
  // the other request lines cannot influence the outputs.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    cand    = prio_idx;
    if (state == LOCKED) begin
      win_vld = reqs[lock_id];
      win_idx = lock_id;
    end else begin
      for (int k = 0; k < p_num_reqs; k++) begin
        if (!win_vld && reqs[cand]) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
        cand = idx_inc(cand);
      end
    end
  end

  // Outputs and next-state; outputs are forced idle while reset is high.
  always_comb begin
    out_val      = win_vld & ~reset;
    sel          = out_val ? win_idx : 2'd0;
    grants       = out_val ? (to_onehot(win_idx) & {p_num_reqs{out_rdy}}) : '0;
    xfer         = out_val & out_rdy;
    state_next   = state;
    prio_next    = prio;
    lock_id_next = lock_id;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          if (req_tail[win_idx]) begin
            prio_next = to_onehot(idx_inc(win_idx));
          end else begin
            state_next   = LOCKED;
            lock_id_next = win_idx;
          end
        end
      end
      LOCKED: begin
        if (xfer && req_tail[lock_id]) begin
          state_next = IDLE;
          prio_next  = to_onehot(idx_inc(lock_id));
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register: arbitration state, priority pointer and lock owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      prio    <= {{(p_num_reqs-1){1'b0}}, 1'b1};
      lock_id <= 2'd0;
    end else begin
      state   <= state_next;
      prio    <= prio_next;
      lock_id <= lock_id_next;
    end
  end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// Bench for plab4_net_router_output_ctrl (N=3): packet-level reference model
// compared every cycle, directed literal vectors, and a random phase.
module tb_plab4_net_router_output_ctrl;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] reqs;
  logic [N-1:0] req_tail;
  logic [N-1:0] grants;
  logic         out_val;
  logic         out_rdy;
  logic [1:0]   sel;

  int checks = 0;
  int errors = 0;

  // Reference model: which input owns the output mid-packet (-1 = none)
  // and the input index that gets first pick for the next packet.
  int m_owner = -1;
  int m_prio  = 0;

  // Observation-side trackers for the packet-integrity and fairness checks.
  int pkt_owner = -1;
  int wait_cnt [N];

  plab4_net_router_output_ctrl #(.p_num_reqs(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .reqs     (reqs),
    .req_tail (req_tail),
    .grants   (grants),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .sel      (sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which input should win this cycle under the packet rules, -1 for none.
  function automatic int exp_winner();
    int idx;
    if (reset) return -1;
    if (m_owner >= 0) begin
      idx = m_owner;
      return reqs[idx[1:0]] ? m_owner : -1;
    end
    for (int k = 0; k < N; k++) begin
      idx = (m_prio + k) % N;
      if (reqs[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // Advance the reference model on each clock edge.
  always @(posedge clk) begin
    int w;
    if (reset) begin
      m_owner = -1;
      m_prio  = 0;
    end else begin
      w = exp_winner();
      if (w >= 0 && out_rdy) begin
        if (req_tail[w[1:0]]) begin
          m_owner = -1;
          m_prio  = (w + 1) % N;
        end else begin
          m_owner = w;
        end
      end
    end
  end

  // Compare DUT outputs with the model mid-cycle, then check packet integrity
  // and fairness from the observed grants.
  always @(negedge clk) begin
    int w;
    int g;
    logic [N-1:0] eg;
    w  = exp_winner();
    eg = (w >= 0 && out_rdy) ? N'(3'b001 << w) : '0;
    chk("model_grants", 32'(grants), 32'(eg));
    chk("model_out_val", 32'(out_val), (w >= 0) ? 32'd1 : 32'd0);
    chk("model_sel", 32'(sel), (w >= 0) ? 32'(w) : 32'd0);
    chk("grants_onehot0", 32'($onehot0(grants)), 32'd1);

    if (reset) begin
      pkt_owner = -1;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      g = -1;
      for (int i = 0; i < N; i++) if (grants[i]) g = i;
      if (g >= 0) begin
        if (pkt_owner >= 0) chk("no_interleave", 32'(g), 32'(pkt_owner));
        pkt_owner = req_tail[g[1:0]] ? -1 : g;
      end
      for (int i = 0; i < N; i++) begin
        if (!reqs[i] || grants[i]) wait_cnt[i] = 0;
      end
      if (g >= 0 && req_tail[g[1:0]]) begin
        for (int i = 0; i < N; i++) begin
          if (i != g && reqs[i]) begin
            wait_cnt[i]++;
            chk("fair_wait_le2", 32'(wait_cnt[i] <= 2), 32'd1);
          end
        end
      end
    end
  end

  task automatic drive(input logic rst_v, input logic [N-1:0] r, input logic [N-1:0] t,
                       input logic rdy);
    @(posedge clk);
    #1;
    reset    = rst_v;
    reqs     = r;
    req_tail = t;
    out_rdy  = rdy;
    #1;
  endtask

  task automatic lit(input string name, input logic [N-1:0] eg, input logic ev,
                     input logic [1:0] es);
    chk({name, "_grants"}, 32'(grants), 32'(eg));
    chk({name, "_val"}, 32'(out_val), 32'(ev));
    chk({name, "_sel"}, 32'(sel), 32'(es));
  endtask

  initial begin
    logic [1:0] rnd;
    logic [1:0] rnd_t;
    reset    = 1'b1;
    reqs     = 3'b111;
    req_tail = 3'b111;
    out_rdy  = 1'b1;
    @(posedge clk);
    #2;
    lit("reset_outputs", 3'b000, 1'b0, 2'd0);

    // Round-robin over single-flit packets, wrapping after input 2.
    drive(1'b0, 3'b111, 3'b111, 1'b1); lit("rr_c0", 3'b001, 1'b1, 2'd0);
    drive(1'b0, 3'b111, 3'b111, 1'b1); lit("rr_c1", 3'b010, 1'b1, 2'd1);
    drive(1'b0, 3'b111, 3'b111, 1'b1); lit("rr_c2", 3'b100, 1'b1, 2'd2);
    drive(1'b0, 3'b111, 3'b111, 1'b1); lit("rr_c3", 3'b001, 1'b1, 2'd0);

    // Backpressure: valid presented but nothing granted, then granted.
    drive(1'b1, 3'b000, 3'b000, 1'b0);
    drive(1'b0, 3'b011, 3'b000, 1'b0); lit("bp_hold", 3'b000, 1'b1, 2'd0);
    drive(1'b0, 3'b011, 3'b000, 1'b1); lit("bp_go", 3'b001, 1'b1, 2'd0);

    // Packet lock with a bubble, tail release, then priority moves on.
    drive(1'b1, 3'b000, 3'b000, 1'b0);
    drive(1'b0, 3'b011, 3'b000, 1'b1); lit("lock_head", 3'b001, 1'b1, 2'd0);
    drive(1'b0, 3'b010, 3'b000, 1'b1); lit("lock_bubble", 3'b000, 1'b0, 2'd0);
    drive(1'b0, 3'b011, 3'b001, 1'b1); lit("lock_tail", 3'b001, 1'b1, 2'd0);
    drive(1'b0, 3'b011, 3'b011, 1'b1); lit("lock_next", 3'b010, 1'b1, 2'd1);

    // Locked on input 2: the other request/tail lines carry garbage.
    drive(1'b1, 3'b000, 3'b000, 1'b0);
    drive(1'b0, 3'b100, 3'b000, 1'b1); lit("l2_head", 3'b100, 1'b1, 2'd2);
    for (int i = 0; i < 4; i++) begin
      rnd   = 2'($urandom);
      rnd_t = 2'($urandom);
      drive(1'b0, {1'b1, rnd}, {1'b0, rnd_t}, 1'b1); lit("l2_body", 3'b100, 1'b1, 2'd2);
    end
    drive(1'b0, 3'b111, 3'b100, 1'b1); lit("l2_tail", 3'b100, 1'b1, 2'd2);
    drive(1'b0, 3'b111, 3'b111, 1'b1); lit("l2_after", 3'b001, 1'b1, 2'd0);

    // Reset mid-packet drops the lock.
    drive(1'b1, 3'b000, 3'b000, 1'b0);
    drive(1'b0, 3'b010, 3'b000, 1'b1); lit("rst_lock", 3'b010, 1'b1, 2'd1);
    drive(1'b1, 3'b010, 3'b000, 1'b1); lit("rst_during", 3'b000, 1'b0, 2'd0);
    drive(1'b0, 3'b011, 3'b011, 1'b1); lit("rst_after", 3'b001, 1'b1, 2'd0);

    // Random traffic, checked by the model and trackers.
    for (int i = 0; i < 1000; i++) begin
      drive(1'b0, 3'($urandom), 3'($urandom_range(0, 7) & $urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0));
    end

    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
